oh_fifo_rr_sched: RTL and testbench

Round-robin read scheduler that shares one downstream consumer between N synchronous FIFOs. Each FIFO presents `empty` and a read port whose data appears the cycle after `rd_en`. The block issues at most one `rd_en` per cycle and collects the returned words into a 2-entry output buffer. It presents them on a valid/wait output interface tagged with the source index. It sits between a bank of per-channel FIFOs and a single-lane emesh/AXI packet path.

---
 rtl/oh_fifo_rr_sched_if.sv | 26 ++
 rtl/oh_fifo_rr_sched.sv | 158 +++++++++++++++
 tb/tb_oh_fifo_rr_sched.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/oh_fifo_rr_sched_if.sv
// Bundle of FIFO-bank read signals and the tagged valid/wait output stream
// shared by the round-robin read scheduler and its environment.
interface oh_fifo_rr_sched_if #(
    parameter int N   = 4,
    parameter int DW  = 104,
    parameter int IDW = 2
);
    logic [N-1:0]    fifo_empty;
    logic [N*DW-1:0] fifo_dout;
    logic [N-1:0]    fifo_rd_en;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [IDW-1:0]  out_src;
    logic            out_wait;
    logic            busy;

    modport master (
        input  fifo_empty, fifo_dout, out_wait,
        output fifo_rd_en, out_valid, out_data, out_src, busy
    );

    modport slave (
        output fifo_empty, fifo_dout, out_wait,
        input  fifo_rd_en, out_valid, out_data, out_src, busy
    );
endinterface

// File: rtl/oh_fifo_rr_sched.sv
// Round-robin read scheduler with burst lock: one read per cycle from N FIFOs
// into a 2-entry output buffer presented as a source-tagged valid/wait stream.
module oh_fifo_rr_sched #(
    parameter int N     = 4,
    parameter int DW    = 104,
    parameter int IDW   = 2,
    parameter int BURST = 4
) (
    input  logic                clk,
    input  logic                nreset,
    oh_fifo_rr_sched_if.master  io_bus
);
    typedef enum logic {S_IDLE, S_LOCK} state_t;

    state_t         r_state, w_state_nxt;
    logic [IDW-1:0] r_ptr, w_ptr_nxt;
    logic [IDW-1:0] r_owner, w_owner_nxt;
    logic [7:0]     r_cnt, w_cnt_nxt;
    logic [IDW-1:0] r_src_d;
    logic           r_pend;
    logic [1:0]     r_buf_cnt;
    logic [DW-1:0]  r_buf_data [2];
    logic [IDW-1:0] r_buf_src  [2];

    logic [N-1:0]   w_req;
    logic [N-1:0]   w_rot;
    logic           w_found;
    logic [IDW-1:0] w_sel;
    logic [IDW-1:0] w_grant;
    logic           w_issue;
    logic           w_pop;
    logic           w_push;
    logic           w_room;
    logic [2:0]     w_occ;
    logic [1:0]     w_wr_pos;
    logic [DW-1:0]  w_cap;

    function automatic logic [IDW-1:0] add_mod(input logic [IDW-1:0] a, input int b);
        int s;
        s = int'(a) + b;
        if (s >= N) s = s - N;
        return IDW'(s);
    endfunction

    assign w_req    = ~io_bus.fifo_empty;
    assign w_pop    = io_bus.out_valid & ~io_bus.out_wait;
    assign w_push   = r_pend;
    assign w_occ    = {1'b0, r_buf_cnt} + {2'b00, r_pend};
    assign w_room   = (w_occ - {2'b00, w_pop}) < 3'd2;
    assign w_wr_pos = r_buf_cnt - {1'b0, w_pop};

    // Rotate requests so bit 0 is the pointer position; first set bit wins.
    assign w_rot = N'({w_req, w_req} >> r_ptr);

    always_comb begin
        w_found = 1'b0;
        w_sel   = r_ptr;
        for (int i = 0; i < N; i++) begin
            if (!w_found && w_rot[i]) begin
                w_found = 1'b1;
                w_sel   = add_mod(r_ptr, i);
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        w_issue     = 1'b0;
        w_grant     = w_sel;
        case (r_state)
            S_IDLE: begin
                if (w_found && w_room) begin
                    w_issue = 1'b1;
                    if (BURST == 1) begin
                        w_ptr_nxt = add_mod(w_sel, 1);
                    end else begin
                        w_state_nxt = S_LOCK;
                        w_owner_nxt = w_sel;
                        w_cnt_nxt   = 8'd1;
                    end
                end
            end
            S_LOCK: begin
                w_grant = r_owner;
                if (w_room) begin
                    if (w_req[r_owner]) begin
                        w_issue   = 1'b1;
                        w_cnt_nxt = r_cnt + 8'd1;
                        if (r_cnt + 8'd1 == 8'(BURST)) begin
                            w_state_nxt = S_IDLE;
                            w_ptr_nxt   = add_mod(r_owner, 1);
                        end
                    end else begin
                        // Owner ran dry: give up the rest of the burst.
                        w_state_nxt = S_IDLE;
                        w_ptr_nxt   = add_mod(r_owner, 1);
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_cap = '0;
        for (int k = 0; k < N; k++) begin
            if (r_src_d == IDW'(k)) w_cap = io_bus.fifo_dout[k*DW +: DW];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_owner   <= '0;
            r_cnt     <= '0;
            r_src_d   <= '0;
            r_pend    <= 1'b0;
            r_buf_cnt <= '0;
            // NOTE: the buffer storage is reset because its head drives
            // out_data, which must read zero out of reset.
            for (int i = 0; i < 2; i++) begin
                r_buf_data[i] <= '0;
                r_buf_src[i]  <= '0;
            end
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_owner   <= w_owner_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pend    <= w_issue;
            if (w_issue) r_src_d <= w_grant;
            r_buf_cnt <= r_buf_cnt + {1'b0, w_push} - {1'b0, w_pop};
            if (w_pop) begin
                r_buf_data[0] <= r_buf_data[1];
                r_buf_src[0]  <= r_buf_src[1];
            end
            // Later assignment wins when the push lands in the slot being shifted into.
            if (w_push) begin
                r_buf_data[w_wr_pos[0]] <= w_cap;
                r_buf_src[w_wr_pos[0]]  <= r_src_d;
            end
        end
    end

    assign io_bus.fifo_rd_en = (w_issue && nreset) ? ({{(N-1){1'b0}}, 1'b1} << w_grant) : '0;
    assign io_bus.out_valid  = (r_buf_cnt != 2'd0);
    assign io_bus.out_data   = r_buf_data[0];
    assign io_bus.out_src    = r_buf_src[0];
    assign io_bus.busy       = r_pend | (r_buf_cnt != 2'd0);
endmodule

// File: tb/tb_oh_fifo_rr_sched.sv
// Scoreboard bench: four scheduler configurations fed by behavioural
// registered-count FIFOs; expected words are queued at load time.
`timescale 1ns/1ps
module tb_oh_fifo_rr_sched;
    localparam int DW = 32;
    localparam int NI = 4;

    typedef struct {
        logic [3:0]    src;
        logic [DW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    logic [DW-1:0] fq [NI][4][$];
    exp_t          exp_q [NI][$];
    logic          wait_r [NI];
    logic [3:0]    rd_en_a [NI];
    logic          valid_a [NI];
    logic          busy_a  [NI];
    logic [3:0]    src_a   [NI];
    logic [DW-1:0] data_a  [NI];
    logic          err_a   [NI];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance 0: N=4 BURST=4, 1: N=4 BURST=1, 2: N=4 BURST=2, 3: N=3 BURST=1.
    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int GN = (g == 3) ? 3 : 4;
        localparam int GB = (g == 0) ? 4 : ((g == 2) ? 2 : 1);
        localparam int GI = $clog2(GN);

        oh_fifo_rr_sched_if #(.N(GN), .DW(DW), .IDW(GI)) bus ();

        oh_fifo_rr_sched #(.N(GN), .DW(DW), .IDW(GI), .BURST(GB)) u_dut (
            .clk    (clk),
            .nreset (nreset),
            .io_bus (bus.master)
        );

        logic [GN-1:0]    m_empty;
        logic [GN*DW-1:0] m_dout;
        logic             m_err;

        initial m_err = 1'b0;

        assign bus.fifo_empty = m_empty;
        assign bus.fifo_dout  = m_dout;
        assign bus.out_wait   = wait_r[g];
        assign rd_en_a[g]     = 4'(bus.fifo_rd_en);
        assign valid_a[g]     = bus.out_valid;
        assign busy_a[g]      = bus.busy;
        assign src_a[g]       = 4'(bus.out_src);
        assign data_a[g]      = bus.out_data;
        assign err_a[g]       = m_err;

        always @(posedge clk) begin
            for (int k = 0; k < GN; k++) begin
                if (!nreset) begin
                    fq[g][k].delete();
                    m_dout[k*DW +: DW] <= '0;
                end else if (bus.fifo_rd_en[k]) begin
                    if (fq[g][k].size() == 0) m_err <= 1'b1;
                    else m_dout[k*DW +: DW] <= fq[g][k].pop_front();
                end
                m_empty[k] <= (fq[g][k].size() == 0);
            end
        end
    end

    always @(negedge clk) begin
        if (nreset) begin
            for (int g = 0; g < NI; g++) begin
                if (valid_a[g] && !wait_r[g]) begin
                    checks++;
                    if (exp_q[g].size() == 0) begin
                        failures++;
                        $display("FAIL out_unexpected inst=%0d got src=%0d data=%h, required no output",
                                 g, src_a[g], data_a[g]);
                    end else begin
                        exp_t e;
                        e = exp_q[g].pop_front();
                        if (src_a[g] !== e.src || data_a[g] !== e.data) begin
                            failures++;
                            $display("FAIL out_word inst=%0d got src=%0d data=%h, required src=%0d data=%h",
                                     g, src_a[g], data_a[g], e.src, e.data);
                        end
                    end
                end
                checks++;
                if (!$onehot0(rd_en_a[g])) begin
                    failures++;
                    $display("FAIL rd_en_onehot inst=%0d got %b, required one-hot or zero", g, rd_en_a[g]);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] word(input int g, input int k, input int i);
        return {8'(g + 1), 8'(k), 16'(i)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int g, input int k, input int n);
        for (int i = 0; i < n; i++) fq[g][k].push_back(word(g, k, i));
    endtask

    task automatic expect_word(input int g, input int k, input int i);
        exp_t e;
        e.src  = 4'(k);
        e.data = word(g, k, i);
        exp_q[g].push_back(e);
    endtask

    task automatic wait_drain(input int g, input int budget, output int left);
        int n;
        n = 0;
        while ((exp_q[g].size() != 0 || busy_a[g]) && n < budget) begin
            @(negedge clk);
            n++;
        end
        left = exp_q[g].size() + (busy_a[g] ? 1 : 0);
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        for (int g = 0; g < NI; g++) wait_r[g] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            checks++;
            if (rd_en_a[g] !== 4'd0 || valid_a[g] !== 1'b0 || data_a[g] !== '0 ||
                src_a[g] !== 4'd0 || busy_a[g] !== 1'b0) begin
                failures++;
                $display("FAIL reset_outputs inst=%0d got rd_en=%b valid=%b data=%h src=%0d busy=%b, required all 0",
                         g, rd_en_a[g], valid_a[g], data_a[g], src_a[g], busy_a[g]);
            end
        end
        checks++;
        if (g_inst[0].u_dut.r_ptr !== 2'd0) begin
            failures++;
            $display("FAIL reset_ptr got %0d, required 0", g_inst[0].u_dut.r_ptr);
        end
        step();
        nreset = 1'b1;
    endtask

    task automatic test_single_channel();
        int  t0, n, left;
        bit  seen;
        step();
        load(0, 2, 6);
        for (int i = 0; i < 6; i++) expect_word(0, 2, i);
        seen = 0; n = 0;
        while (!seen && n < 20) begin
            @(negedge clk); n++;
            if (rd_en_a[0] !== 4'd0) seen = 1;
        end
        checks++;
        if (rd_en_a[0] !== 4'b0100) begin
            failures++;
            $display("FAIL single_first_rd_en got %b, required 0100", rd_en_a[0]);
        end
        t0 = cyc;
        seen = 0; n = 0;
        while (!seen && n < 20) begin
            @(negedge clk); n++;
            if (valid_a[0] === 1'b1) seen = 1;
        end
        checks++;
        if (cyc - t0 !== 2) begin
            failures++;
            $display("FAIL single_latency got %0d cycles, required 2", cyc - t0);
        end
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (valid_a[0] === 1'b1) n++;
            if (i < 5) @(negedge clk);
        end
        checks++;
        if (n !== 6) begin
            failures++;
            $display("FAIL single_gapless got %0d valid cycles, required 6", n);
        end
        wait_drain(0, 40, left);
        checks++;
        if (left !== 0) begin
            failures++;
            $display("FAIL single_drain got %0d outstanding, required 0", left);
        end
    endtask

    task automatic test_fairness();
        int left;
        step();
        for (int k = 0; k < 4; k++) load(1, k, 3);
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < 4; k++) expect_word(1, k, i);
        wait_drain(1, 60, left);
        checks++;
        if (left !== 0) begin
            failures++;
            $display("FAIL fairness_drain got %0d outstanding, required 0", left);
        end
    endtask

    task automatic test_burst_lock();
        int seq [10];
        int c0, c1, left;
        seq = '{0, 0, 1, 1, 0, 0, 1, 1, 0, 1};
        c0 = 0; c1 = 0;
        step();
        load(2, 0, 5);
        load(2, 1, 5);
        for (int i = 0; i < 10; i++) begin
            if (seq[i] == 0) begin expect_word(2, 0, c0); c0++; end
            else begin expect_word(2, 1, c1); c1++; end
        end
        wait_drain(2, 60, left);
        checks++;
        if (left !== 0) begin
            failures++;
            $display("FAIL burst_drain got %0d outstanding, required 0", left);
        end
    endtask

    task automatic test_backpressure();
        int pulses, n, left;
        step();
        wait_r[0] = 1'b1;
        load(0, 0, 8);
        for (int i = 0; i < 8; i++) expect_word(0, 0, i);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rd_en_a[0] !== 4'd0) pulses++;
        end
        checks++;
        if (pulses !== 2) begin
            failures++;
            $display("FAIL bp_rd_pulses got %0d, required 2", pulses);
        end
        checks++;
        if (rd_en_a[0] !== 4'd0) begin
            failures++;
            $display("FAIL bp_issue_stopped got rd_en=%b, required 0000", rd_en_a[0]);
        end
        checks++;
        if (valid_a[0] !== 1'b1 || data_a[0] !== word(0, 0, 0)) begin
            failures++;
            $display("FAIL bp_head_held got valid=%b data=%h, required valid=1 data=%h",
                     valid_a[0], data_a[0], word(0, 0, 0));
        end
        step();
        wait_r[0] = 1'b0;
        #1;
        checks++;
        if (rd_en_a[0] !== 4'b0001) begin
            failures++;
            $display("FAIL bp_resume got rd_en=%b, required 0001", rd_en_a[0]);
        end
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (valid_a[0] === 1'b1) n++;
        end
        checks++;
        if (n !== 8) begin
            failures++;
            $display("FAIL bp_gapless got %0d valid cycles, required 8", n);
        end
        wait_drain(0, 40, left);
        checks++;
        if (left !== 0) begin
            failures++;
            $display("FAIL bp_drain got %0d outstanding, required 0", left);
        end
    endtask

    task automatic test_wrap();
        int  n, left;
        bit  seen;
        step();
        load(3, 1, 1);
        expect_word(3, 1, 0);
        wait_drain(3, 30, left);
        checks++;
        if (left !== 0 || g_inst[3].u_dut.r_ptr !== 2'd2) begin
            failures++;
            $display("FAIL wrap_setup got outstanding=%0d ptr=%0d, required 0 and 2",
                     left, g_inst[3].u_dut.r_ptr);
        end
        step();
        load(3, 2, 2);
        load(3, 0, 2);
        for (int i = 0; i < 2; i++) begin
            expect_word(3, 2, i);
            expect_word(3, 0, i);
        end
        seen = 0; n = 0;
        while (!seen && n < 20) begin
            @(negedge clk); n++;
            if (rd_en_a[3] !== 4'd0) seen = 1;
        end
        checks++;
        if (rd_en_a[3] !== 4'b0100) begin
            failures++;
            $display("FAIL wrap_first_grant got %b, required 0100", rd_en_a[3]);
        end
        @(negedge clk);
        checks++;
        if (g_inst[3].u_dut.r_ptr !== 2'd0 || rd_en_a[3] !== 4'b0001) begin
            failures++;
            $display("FAIL wrap_ptr got ptr=%0d rd_en=%b, required ptr=0 rd_en=0001",
                     g_inst[3].u_dut.r_ptr, rd_en_a[3]);
        end
        @(negedge clk);
        checks++;
        if (g_inst[3].u_dut.r_ptr !== 2'd1) begin
            failures++;
            $display("FAIL wrap_ptr_after0 got %0d, required 1", g_inst[3].u_dut.r_ptr);
        end
        wait_drain(3, 30, left);
        checks++;
        if (left !== 0) begin
            failures++;
            $display("FAIL wrap_drain got %0d outstanding, required 0", left);
        end
    endtask

    task automatic test_midop_reset();
        int  n, left;
        bit  seen;
        step();
        wait_r[0] = 1'b1;
        load(0, 0, 4);
        load(0, 1, 4);
        repeat (4) @(negedge clk);
        checks++;
        if (busy_a[0] !== 1'b1 || valid_a[0] !== 1'b1) begin
            failures++;
            $display("FAIL midop_precondition got busy=%b valid=%b, required 1 1", busy_a[0], valid_a[0]);
        end
        step();
        nreset = 1'b0;
        step();
        nreset = 1'b1;
        @(negedge clk);
        checks++;
        if (valid_a[0] !== 1'b0 || busy_a[0] !== 1'b0 || rd_en_a[0] !== 4'd0 ||
            g_inst[0].u_dut.r_ptr !== 2'd0) begin
            failures++;
            $display("FAIL midop_cleared got valid=%b busy=%b rd_en=%b ptr=%0d, required 0 0 0000 0",
                     valid_a[0], busy_a[0], rd_en_a[0], g_inst[0].u_dut.r_ptr);
        end
        step();
        wait_r[0] = 1'b0;
        load(0, 1, 1);
        load(0, 0, 1);
        expect_word(0, 0, 0);
        expect_word(0, 1, 0);
        seen = 0; n = 0;
        while (!seen && n < 20) begin
            @(negedge clk); n++;
            if (rd_en_a[0] !== 4'd0) seen = 1;
        end
        checks++;
        if (rd_en_a[0] !== 4'b0001) begin
            failures++;
            $display("FAIL midop_first_after_reset got %b, required 0001", rd_en_a[0]);
        end
        wait_drain(0, 30, left);
        checks++;
        if (left !== 0) begin
            failures++;
            $display("FAIL midop_drain got %0d outstanding, required 0", left);
        end
    endtask

    task automatic test_no_empty_reads();
        for (int g = 0; g < NI; g++) begin
            checks++;
            if (err_a[g] !== 1'b0) begin
                failures++;
                $display("FAIL read_of_empty inst=%0d got flag=%b, required 0", g, err_a[g]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_channel();
        test_fairness();
        test_burst_lock();
        test_backpressure();
        test_wrap();
        test_midop_reset();
        test_no_empty_reads();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
